// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a ready handshake.
// Illegal or misaligned operations park the core in an absorbing TRAP state until reset.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DBG_A    = 1,
    parameter int unsigned DBG_B    = 31
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] pc_out_o,
    output logic [31:0] inst_out_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [31:0] dbg_a_o,
    output logic [31:0] dbg_b_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] DBG_A_IDX = DBG_A[4:0];
    localparam logic [4:0] DBG_B_IDX = DBG_B[4:0];

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext, addr_sum;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign addr_sum = a_q + imm_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        tgt_d    = tgt_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        trap_d   = trap_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;

        case (state_q)
            S_FETCH: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end else if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                imm_d   = (op == OP_ANDI || op == OP_ORI) ? imm_zext : imm_sext;
                tgt_d   = pc_q + {imm_sext[29:0], 2'b00};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD: alu_d = a_q + b_q;
                            FN_SUB: alu_d = a_q - b_q;
                            FN_AND: alu_d = a_q & b_q;
                            FN_OR:  alu_d = a_q | b_q;
                            FN_SLT: alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            FN_SLL: alu_d = b_q << shamt;
                            FN_SRL: alu_d = b_q >> shamt;
                            FN_JR: begin
                                pc_d     = a_q;
                                retire_d = 1'b1;
                                state_d  = S_FETCH;
                            end
                            default: begin
                                state_d = S_TRAP;
                                trap_d  = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI: alu_d = a_q + imm_q;
                    OP_ANDI: alu_d = a_q & imm_q;
                    OP_ORI:  alu_d = a_q | imm_q;
                    OP_LUI:  alu_d = {ir_q[15:0], 16'h0000};
                    OP_LW, OP_SW: begin
                        alu_d = addr_sum;
                        if (addr_sum[1:0] != 2'b00) begin
                            state_d = S_TRAP;
                            trap_d  = 1'b1;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) == (op == OP_BEQ)) pc_d = tgt_q;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        // pc_q already holds the jump's address + 4, which is also the link value
                        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                        rf_we    = (op == OP_JAL);
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    if (op == OP_LW) begin
                        mdr_d   = mem_rdata_i;
                        state_d = S_WB;
                    end else begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_we    = (rf_waddr != 5'd0);
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
                trap_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            imm_q    <= 32'd0;
            tgt_q    <= 32'd0;
            alu_q    <= 32'd0;
            mdr_q    <= 32'd0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            tgt_q    <= tgt_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
        end
    end

    // R0 is never written, so it reads as zero without a read-side mux
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Request is gated by rst so a pending transaction drops the moment reset asserts
    assign mem_req_o   = ~rst_i & (((state_q == S_FETCH) && (pc_q[1:0] == 2'b00)) || (state_q == S_MEM));
    assign mem_we_o    = (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr_o  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata_o = b_q;

    assign pc_out_o   = pc_q;
    assign inst_out_o = ir_q;
    assign retire_o   = retire_q;
    assign trap_o     = trap_q;
    assign dbg_a_o    = regs_q[DBG_A_IDX];
    assign dbg_b_o    = regs_q[DBG_B_IDX];

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: unified memory model with programmable wait states,
// hand-assembled programs and immediate-assertion checks sampled just after each falling edge.
module tb_mc_cpu_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memReq, memWe, memReady, retire, trap;
    logic [31:0] memAddr, memWdata, memRdata, pcOut, instOut, dbgA, dbgB;

    logic [31:0] mem [0:1023];
    int          waitCycles = 0;
    int          waitCnt;
    int          checks = 0;
    int          errors = 0;
    int          wrCycles = 0;
    logic [31:0] expWrAddr = 32'd0;
    logic [31:0] expWrData = 32'd0;
    int          lat;
    int          reqCount;

    mc_cpu_core #(
        .RESET_PC(32'h0000_0100),
        .DBG_A(1),
        .DBG_B(31)
    ) dut (
        .clk_i(clock),
        .rst_i(reset),
        .mem_req_o(memReq),
        .mem_we_o(memWe),
        .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata),
        .mem_ready_i(memReady),
        .pc_out_o(pcOut),
        .inst_out_o(instOut),
        .retire_o(retire),
        .trap_o(trap),
        .dbg_a_o(dbgA),
        .dbg_b_o(dbgB)
    );

    always #5 clock = ~clock;

    // Memory model: ready rises after waitCycles cycles of an outstanding request
    assign memRdata = mem[memAddr[11:2]];
    assign memReady = (waitCycles == 0) ? 1'b1 : (waitCnt == waitCycles);

    always @(posedge clock or posedge reset) begin
        if (reset || !memReq || memReady) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    always @(posedge clock) begin
        if (!reset && memReq && memReady && memWe) mem[memAddr[11:2]] = memWdata;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int waits);
        @(negedge clock);
        reset = 1'b1;
        waitCycles = waits;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic waitRetire(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (memReq && memWe) begin
                wrCycles++;
                checkOutput("swAddr", memAddr, expWrAddr);
                checkOutput("swWdata", memWdata, expWrData);
            end
            if (retire) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic stepInstr(input string tag, input int expLat);
        int l;
        waitRetire(l);
        checkOutput({tag, "Latency"}, l, expLat);
    endtask

    initial begin
        $display("[TB] mc_cpu_core directed test start");

        // Reset values and first fetch
        applyStimulus(0);
        mem[64] = 32'h2001_0005;
        checkOutput("rstMemReq", memReq, 0);
        checkOutput("rstMemWe", memWe, 0);
        checkOutput("rstMemAddr", memAddr, 32'h100);
        checkOutput("rstMemWdata", memWdata, 0);
        checkOutput("rstPc", pcOut, 32'h100);
        checkOutput("rstInst", instOut, 0);
        checkOutput("rstRetire", retire, 0);
        checkOutput("rstTrap", trap, 0);
        checkOutput("rstDbgB", dbgB, 0);
        releaseReset();
        checkOutput("firstReq", memReq, 1);
        checkOutput("firstAddr", memAddr, 32'h100);
        stepInstr("addiFirst", 4);
        checkOutput("addiDbgA", dbgA, 5);
        checkOutput("addiPc", pcOut, 32'h104);
        checkOutput("addiInst", instOut, 32'h2001_0005);

        // ALU sequence
        applyStimulus(0);
        mem[64] = 32'h2002_FFFD;
        mem[65] = 32'h2003_0007;
        mem[66] = 32'h0043_0820;
        mem[67] = 32'h0043_202A;
        mem[68] = 32'h0080_F820;
        mem[69] = 32'h3C05_1234;
        mem[70] = 32'h34A5_FFFF;
        mem[71] = 32'h00A0_F820;
        mem[72] = 32'h2000_0009;
        mem[73] = 32'h0043_0020;
        mem[74] = 32'h0000_F820;
        mem[75] = 32'h0062_0822;
        mem[76] = 32'h0043_0824;
        mem[77] = 32'h0043_0825;
        mem[78] = 32'h0003_0900;
        mem[79] = 32'h0002_0F02;
        mem[80] = 32'h0062_082A;
        mem[81] = 32'h3041_FF00;
        releaseReset();
        stepInstr("addiNeg", 4);
        stepInstr("addi7", 4);
        stepInstr("add", 4);
        checkOutput("addResult", dbgA, 32'd4);
        stepInstr("slt", 4);
        stepInstr("movSlt", 4);
        checkOutput("sltResult", dbgB, 32'd1);
        stepInstr("lui", 4);
        stepInstr("ori", 4);
        stepInstr("movLuiOri", 4);
        checkOutput("luiOriResult", dbgB, 32'h1234_FFFF);
        stepInstr("addiR0", 4);
        stepInstr("addR0", 4);
        stepInstr("movR0", 4);
        checkOutput("r0StaysZero", dbgB, 32'd0);
        stepInstr("sub", 4);
        checkOutput("subResult", dbgA, 32'd10);
        stepInstr("and", 4);
        checkOutput("andResult", dbgA, 32'd5);
        stepInstr("or", 4);
        checkOutput("orResult", dbgA, 32'hFFFF_FFFF);
        stepInstr("sll", 4);
        checkOutput("sllResult", dbgA, 32'h70);
        stepInstr("srl", 4);
        checkOutput("srlResult", dbgA, 32'hF);
        stepInstr("sltSigned", 4);
        checkOutput("sltSignedResult", dbgA, 32'd0);
        stepInstr("andi", 4);
        checkOutput("andiResult", dbgA, 32'h0000_FF00);

        // Memory with two wait states per access
        applyStimulus(2);
        mem[64] = 32'h2003_0007;
        mem[65] = 32'hAC03_0008;
        mem[66] = 32'h8C01_0008;
        expWrAddr = 32'h8;
        expWrData = 32'h7;
        wrCycles = 0;
        releaseReset();
        stepInstr("addiWait", 6);
        stepInstr("swWait", 8);
        checkOutput("swHeldCycles", wrCycles, 3);
        checkOutput("swMemContents", mem[2], 32'h7);
        stepInstr("lwWait", 9);
        checkOutput("lwResult", dbgA, 32'h7);

        // Control flow
        applyStimulus(0);
        mem[64]  = 32'h0800_0004;
        mem[4]   = 32'h1000_0002;
        mem[5]   = 32'hFC00_0000;
        mem[6]   = 32'h2001_0055;
        mem[7]   = 32'h1400_0005;
        mem[8]   = 32'h0C00_0080;
        mem[9]   = 32'h1000_FFFC;
        mem[128] = 32'h2001_0001;
        mem[129] = 32'h1020_0004;
        mem[130] = 32'h1420_0001;
        mem[131] = 32'hFC00_0000;
        mem[132] = 32'h03E0_0008;
        releaseReset();
        stepInstr("j", 3);
        checkOutput("jFetch", memAddr, 32'h10);
        stepInstr("beqTaken", 3);
        checkOutput("beqTakenFetch", memAddr, 32'h1C);
        checkOutput("beqTakenReq", memReq, 1);
        stepInstr("bneNotTaken", 3);
        checkOutput("bneNotTakenFetch", memAddr, 32'h20);
        stepInstr("jal", 3);
        checkOutput("jalLink", dbgB, 32'h24);
        checkOutput("jalFetch", memAddr, 32'h200);
        stepInstr("addi1", 4);
        stepInstr("beqNotTaken", 3);
        checkOutput("beqNotTakenFetch", memAddr, 32'h208);
        stepInstr("bneTaken", 3);
        checkOutput("bneTakenFetch", memAddr, 32'h210);
        stepInstr("jr", 3);
        checkOutput("jrFetch", memAddr, 32'h24);
        stepInstr("beqBackward", 3);
        checkOutput("beqBackwardFetch", memAddr, 32'h18);
        stepInstr("addi55", 4);
        checkOutput("addi55Result", dbgA, 32'h55);
        checkOutput("ctrlNoTrap", trap, 0);

        // Trap on illegal opcode
        applyStimulus(0);
        mem[64] = 32'hFC00_0000;
        releaseReset();
        tick();
        tick();
        checkOutput("illegalTrapEarly", trap, 0);
        tick();
        checkOutput("illegalTrap", trap, 1);
        reqCount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (memReq || retire) reqCount++;
        end
        checkOutput("illegalQuiet", reqCount, 0);
        checkOutput("illegalPcFrozen", pcOut, 32'h104);
        checkOutput("illegalInstFrozen", instOut, 32'hFC00_0000);
        reset = 1'b1;
        #1;
        checkOutput("illegalRstClears", trap, 0);

        // Trap on illegal R-type funct
        applyStimulus(0);
        mem[64] = 32'h0000_003F;
        releaseReset();
        tick();
        tick();
        tick();
        checkOutput("badFunctTrap", trap, 1);

        // Trap on misaligned lw, with no data request
        applyStimulus(0);
        mem[64] = 32'h8C01_0006;
        releaseReset();
        reqCount = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (memReq) reqCount++;
            if (i == 3) checkOutput("lwMisalignTrap", trap, 1);
        end
        checkOutput("lwMisalignNoReq", reqCount, 0);
        reset = 1'b1;
        #1;
        checkOutput("lwMisalignRstClears", trap, 0);

        // Trap on jr to a misaligned target
        applyStimulus(0);
        mem[64] = 32'h2001_0102;
        mem[65] = 32'h0020_0008;
        releaseReset();
        stepInstr("addi102", 4);
        stepInstr("jrMisalign", 3);
        checkOutput("jrMisalignNoFetch", memReq, 0);
        checkOutput("jrMisalignPc", pcOut, 32'h102);
        tick();
        checkOutput("jrMisalignTrap", trap, 1);
        checkOutput("jrMisalignQuiet", memReq, 0);
        reset = 1'b1;
        #1;
        checkOutput("jrMisalignRstClears", trap, 0);

        // Reset while a fetch is waiting on ready
        applyStimulus(3);
        mem[64] = 32'h2001_0005;
        mem[65] = 32'h201F_0009;
        releaseReset();
        stepInstr("addiSlow", 7);
        checkOutput("slowDbgA", dbgA, 32'd5);
        checkOutput("pendingReq", memReq, 1);
        checkOutput("pendingNotReady", memReady, 0);
        reset = 1'b1;
        #1;
        checkOutput("midRstReqDrop", memReq, 0);
        checkOutput("midRstPc", pcOut, 32'h100);
        checkOutput("midRstRegs", dbgA, 32'd0);
        tick();
        releaseReset();
        checkOutput("resumeReq", memReq, 1);
        checkOutput("resumeAddr", memAddr, 32'h100);
        stepInstr("addiResume", 7);
        checkOutput("resumeDbgA", dbgA, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
